// File: rtl/adder_serial_ctrl.sv
// adder_serial_ctrl
//   Sequencer for a bit-serial adder. It takes a WIDTH-bit operand pair plus a
//   carry-in over a valid/ready handshake. It presents one bit per step to the
//   adder, LSB first. Each bit is held for ADDER_LAT cycles, and the adder's
//   carry-out is returned as the carry-in of the next bit. The sum bits are
//   assembled into a parallel result that a valid/ready consumer picks up.
//
//   Optional feature macro: ADDER_CTRL_SUB_EN
//     Adds the in_sub port. When in_sub is 1 at accept, the adder is fed
//     A + ~B + 1 (A - B), and out_cout=1 means no borrow.
//
// Ports
//   clk        : clock, rising edge
//   p_reset    : asynchronous active-high reset
//   in_valid   : operand request
//   in_ready   : idle and accepting
//   in_a, in_b : operands (WIDTH bits)
//   in_cin     : carry-in
//   in_sub     : subtract request (ADDER_CTRL_SUB_EN only)
//   add_ai     : adder Ai
//   add_bi     : adder Bi
//   add_ci     : adder Ci
//   add_f      : adder sum bit f
//   add_co     : adder carry co
//   out_valid  : result available
//   out_ready  : consumer accepts result
//   out_sum    : assembled sum
//   out_cout   : final carry-out
//   busy       : high while running or holding a result
//
// States
//   IDLE | waiting for a request, in_ready=1
//   RUN  | presenting operand bits to the adder, one bit per ADDER_LAT cycles
//   DONE | result held, out_valid=1 until out_ready

module adder_serial_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ADDER_LAT = 1
) (
  input  logic             clk,
  input  logic             p_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef ADDER_CTRL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             add_ai,
  output logic             add_bi,
  output logic             add_ci,
  input  logic             add_f,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int STEP_W = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WIDTH - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ADDER_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry_reg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [STEP_W-1:0] step_cnt;

  logic accept;
  logic capture;
  logic last_bit;

  assign last_bit = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs and adder drives depend only on state and registers.
  // No input reaches them combinationally.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    add_ai    = 1'b0;
    add_bi    = 1'b0;
    add_ci    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        add_ai = a_reg[0];
        add_bi = b_reg[0];
        add_ci = carry_reg;
        if (step_cnt == LAST_STEP) begin
          capture = 1'b1;
          if (last_bit) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      bit_cnt   <= '0;
      step_cnt  <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
`ifdef ADDER_CTRL_SUB_EN
      // Subtraction uses A + ~B + 1, so in_cin has no effect here.
      b_reg     <= in_sub ? ~in_b : in_b;
      carry_reg <= in_sub ? 1'b1 : in_cin;
`else
      b_reg     <= in_b;
      carry_reg <= in_cin;
`endif
      bit_cnt  <= '0;
      step_cnt <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (state == RUN) begin
      if (capture) begin
        out_sum[bit_cnt] <= add_f;
        carry_reg        <= add_co;
        a_reg            <= a_reg >> 1;
        b_reg            <= b_reg >> 1;
        bit_cnt          <= bit_cnt + 1'b1;
        step_cnt         <= '0;
        if (last_bit) begin
          out_cout <= add_co;
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_ctrl.sv
module tb_adder_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        p_reset;
  logic [31:0] in_a, in_b;
  logic        in_cin;
`ifdef ADDER_CTRL_SUB_EN
  logic        in_sub;
`endif

  // Instance with ADDER_LAT=1
  logic        in_valid0, in_ready0, out_ready0, out_valid0, out_cout0, busy0;
  logic        ai0, bi0, ci0, f0, co0;
  logic [31:0] sum0;

  // Instance with ADDER_LAT=3
  logic        in_valid3, in_ready3, out_ready3, out_valid3, out_cout3, busy3;
  logic        ai3, bi3, ci3, f3, co3;
  logic [31:0] sum3;
  logic [2:0]  pipe1, pipe2;

  int tests = 0;
  int fails = 0;

  // The one-cycle adder is a full adder that the controller samples at the next edge.
  assign f0  = ai0 ^ bi0 ^ ci0;
  assign co0 = (ai0 & bi0) | (ai0 & ci0) | (bi0 & ci0);

  // The three-cycle adder reads its inputs through two pipeline registers.
  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      pipe1 <= 3'b0;
      pipe2 <= 3'b0;
    end else begin
      pipe1 <= {ai3, bi3, ci3};
      pipe2 <= pipe1;
    end
  end
  assign f3  = ^pipe2;
  assign co3 = (pipe2[2] & pipe2[1]) | (pipe2[2] & pipe2[0]) | (pipe2[1] & pipe2[0]);

  adder_serial_ctrl #(.WIDTH(32), .ADDER_LAT(1)) dut (
    .clk(clk), .p_reset(p_reset),
    .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef ADDER_CTRL_SUB_EN
    .in_sub(in_sub),
`endif
    .add_ai(ai0), .add_bi(bi0), .add_ci(ci0), .add_f(f0), .add_co(co0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_sum(sum0), .out_cout(out_cout0), .busy(busy0)
  );

  adder_serial_ctrl #(.WIDTH(32), .ADDER_LAT(3)) dut3 (
    .clk(clk), .p_reset(p_reset),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef ADDER_CTRL_SUB_EN
    .in_sub(in_sub),
`endif
    .add_ai(ai3), .add_bi(bi3), .add_ci(ci3), .add_f(f3), .add_co(co3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_sum(sum3), .out_cout(out_cout3), .busy(busy3)
  );

  // Every task starts and ends 1 time unit after a rising edge.

  task automatic start0(input logic [31:0] a, input logic [31:0] b, input logic cin);
    in_a = a; in_b = b; in_cin = cin;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    while (!out_valid0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drain0();
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
  endtask

  // Runs one complete add on the ADDER_LAT=1 instance and checks it.
  task automatic run_add0(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] exp_sum, input logic exp_cout);
    int n;
    start0(a, b, cin);
    tests++;
    if (in_ready0 !== 1'b0 || busy0 !== 1'b1) begin
      fails++;
      $display("FAIL %s_accept: in_ready=%b busy=%b, required in_ready=0 busy=1", name, in_ready0, busy0);
    end
    wait_valid0(n);
    tests++;
    if (n !== 32) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, required 32", name, n);
    end
    tests++;
    if (sum0 !== exp_sum || out_cout0 !== exp_cout) begin
      fails++;
      $display("FAIL %s_result: got sum=%h cout=%b, required sum=%h cout=%b",
               name, sum0, out_cout0, exp_sum, exp_cout);
    end
    drain0();
    tests++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
               name, in_ready0, out_valid0, busy0);
    end
  endtask

  task automatic test_reset();
    p_reset = 1'b1;
    #2;
    tests++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0 || sum0 !== 32'h0 ||
        out_cout0 !== 1'b0 || {ai0, bi0, ci0} !== 3'b000 || in_ready3 !== 1'b1 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b add=%b%b%b",
               in_ready0, busy0, out_valid0, sum0, out_cout0, ai0, bi0, ci0);
    end
    @(negedge clk);
    p_reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b out_valid=%b, required 1/0/0",
               in_ready0, busy0, out_valid0);
    end
  endtask

  task automatic test_basic();
    run_add0("add_3_5", 32'd3, 32'd5, 1'b0, 32'd8, 1'b0);
  endtask

  task automatic test_boundary();
    run_add0("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1);
    run_add0("msb_cin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h1, 1'b1);
  endtask

  task automatic test_hold_and_ignore();
    int n;
    int bad;
    start0(32'h0000_1234, 32'h0000_4321, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    in_valid0 = 1'b1;
    tests++;
    if (in_ready0 !== 1'b0) begin
      fails++;
      $display("FAIL ignore_run_ready: in_ready=%b, required 0", in_ready0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_valid0(n);
    tests++;
    if (n !== 26 || sum0 !== 32'h0000_5555 || out_cout0 !== 1'b0) begin
      fails++;
      $display("FAIL ignore_run_result: got cycles=%0d sum=%h cout=%b, required 26 00005555 0",
               n, sum0, out_cout0);
    end
    bad = 0;
    in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid0 !== 1'b1 || sum0 !== 32'h0000_5555 || out_cout0 !== 1'b0 || in_ready0 !== 1'b0)
        bad++;
    end
    in_valid0 = 1'b0;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL done_hold: %0d unstable cycles, required 0 (last sum=%h out_valid=%b)",
               bad, sum0, out_valid0);
    end
    drain0();
    @(posedge clk); #1;
    tests++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL ignore_done: in_ready=%b busy=%b, required 1/0", in_ready0, busy0);
    end
  endtask

  task automatic test_reset_mid_run();
    start0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    tests++;
    if ({ai0, bi0, ci0} !== 3'b111 || sum0 !== 32'h0000_03FE) begin
      fails++;
      $display("FAIL bit10_state: add=%b%b%b sum=%h, required 111 000003fe", ai0, bi0, ci0, sum0);
    end
    #2;
    p_reset = 1'b1;
    #1;
    tests++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0 || out_valid0 !== 1'b0 || sum0 !== 32'h0 ||
        out_cout0 !== 1'b0 || {ai0, bi0, ci0} !== 3'b000) begin
      fails++;
      $display("FAIL abort_reset: in_ready=%b busy=%b out_valid=%b sum=%h cout=%b add=%b%b%b",
               in_ready0, busy0, out_valid0, sum0, out_cout0, ai0, bi0, ci0);
    end
    @(negedge clk);
    p_reset = 1'b0;
    @(posedge clk); #1;
    run_add0("after_reset", 32'd7, 32'd9, 1'b0, 32'd16, 1'b0);
  endtask

  task automatic test_lat3();
    logic [31:0] a, b;
    logic [32:0] c;
    int bad_drive;
    int early;
    a = 32'h1234_5678;
    b = 32'h0FED_CBA9;
    c[0] = 1'b1;
    for (int k = 0; k < 32; k++)
      c[k+1] = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
    in_a = a; in_b = b; in_cin = 1'b1;
    in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    bad_drive = 0;
    early = 0;
    for (int j = 0; j < 96; j++) begin
      if (ai3 !== a[j/3] || bi3 !== b[j/3] || ci3 !== c[j/3]) bad_drive++;
      if (out_valid3 !== 1'b0) early++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad_drive !== 0) begin
      fails++;
      $display("FAIL lat3_drive: %0d cycles with wrong add_ai/bi/ci, required 0", bad_drive);
    end
    tests++;
    if (early !== 0 || out_valid3 !== 1'b1) begin
      fails++;
      $display("FAIL lat3_latency: early=%0d out_valid=%b after 96 cycles, required 0 and 1",
               early, out_valid3);
    end
    tests++;
    if (sum3 !== 32'h2222_2222 || out_cout3 !== 1'b0) begin
      fails++;
      $display("FAIL lat3_result: got sum=%h cout=%b, required 22222222 0", sum3, out_cout3);
    end
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
    tests++;
    if (in_ready3 !== 1'b1 || busy3 !== 1'b0) begin
      fails++;
      $display("FAIL lat3_drain: in_ready=%b busy=%b, required 1/0", in_ready3, busy3);
    end
  endtask

`ifdef ADDER_CTRL_SUB_EN
  task automatic test_sub();
    in_sub = 1'b1;
    run_add0("sub_5_3", 32'd5, 32'd3, 1'b0, 32'd2, 1'b1);
    run_add0("sub_3_5", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0);
    in_sub = 1'b0;
  endtask
`endif

  initial begin
    p_reset    = 1'b1;
    in_a       = '0;
    in_b       = '0;
    in_cin     = 1'b0;
`ifdef ADDER_CTRL_SUB_EN
    in_sub     = 1'b0;
`endif
    in_valid0  = 1'b0;
    out_ready0 = 1'b0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b0;

    test_reset();
    test_basic();
    test_boundary();
    test_hold_and_ignore();
    test_reset_mid_run();
    test_lat3();
`ifdef ADDER_CTRL_SUB_EN
    test_sub();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_serial_ctrl.md
# adder_serial_ctrl

Sequencer for the bit-serial `adder_32bits` datapath. It accepts a pair of WIDTH-bit operands plus carry-in over a valid/ready handshake and feeds them to the adder one bit per step, LSB first. It closes the carry loop by returning the adder's `co` to `Ci` for the next bit, then assembles the sum bits into a parallel result held for a valid/ready consumer. It sits between a parallel requester and one adder instance, and shares the adder's clock and reset.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `ADDER_LAT`, 1: adder latency in cycles, from `Ai/Bi/Ci` driven to `f/co` valid. Must be ≥1.

- `clk` in 1: single clock; all state updates on rising edge.
- `p_reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: controller idle and accepting.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_cin` in 1: carry-in.
- `in_sub` in 1: subtract request. Present only with `ADDER_CTRL_SUB_EN`.
- `add_ai` out 1: drives adder `Ai`.
- `add_bi` out 1: drives adder `Bi`.
- `add_ci` out 1: drives adder `Ci`.
- `add_f` in 1: adder sum bit `f`.
- `add_co` in 1: adder carry `co`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts result.
- `out_sum` out WIDTH: assembled sum.
- `out_cout` out 1: final carry-out.
- `busy` out 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: shifting bits.
  - DONE: `out_valid`=1.
- IDLE→RUN on an edge with `in_valid`=1. The controller latches `in_a`, `in_b` and `in_cin` into shift/carry registers and clears `bit_cnt`, `step_cnt` and `out_sum`.
- RUN drives:
  - `add_ai` = A-reg[0]
  - `add_bi` = B-reg[0]
  - `add_ci` = carry-reg
- RUN holds these stable for ADDER_LAT cycles per bit, counted by `step_cnt`.
- At the edge where `step_cnt`==ADDER_LAT-1:
  - `out_sum[bit_cnt]` ← `add_f`.
  - carry-reg ← `add_co`.
  - A-reg and B-reg shift right by 1.
  - `bit_cnt` increments and `step_cnt` clears.
- RUN→DONE on the capture edge of bit WIDTH-1. `out_cout` ← `add_co` on that edge.
- DONE→IDLE on an edge with `out_ready`=1. `out_sum` and `out_cout` hold their values until the next accept.
- Outside RUN, `add_ai`, `add_bi` and `add_ci` are 0.
- `in_valid` is ignored while not IDLE. It is never queued.
- Width rules:
  - `bit_cnt` is ⌈log2 WIDTH⌉ bits.
  - `step_cnt` is ⌈log2 ADDER_LAT⌉ bits, minimum 1.
  - No arithmetic is done locally; the sum comes only from the adder.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1.
  - `busy`=0, `out_valid`=0.
  - `out_sum`=0, `out_cout`=0.
  - `add_ai`, `add_bi`, `add_ci` = 0.
  - All counters and registers 0.
- Accept at edge E0 → bit 0 driven in the cycle after E0. Bit k is captured at edge E0+(k+1)·ADDER_LAT.
- `out_valid` rises after edge E0+WIDTH·ADDER_LAT, which is 32 cycles at default parameters.
- The DONE→IDLE edge makes `in_ready` high the following cycle. There is no same-cycle result drain and new accept.
- `in_ready`, `out_valid` and `busy` are decoded from state registers, with no combinational path from inputs.
- `p_reset` mid-RUN or mid-DONE aborts immediately and asynchronously: the partial result is discarded and every output takes its reset value.
- `out_ready` held low keeps DONE indefinitely, with `out_sum` and `out_cout` stable.

## Configuration
- `ADDER_CTRL_SUB_EN` defined:
  - Adds the `in_sub` port.
  - When `in_sub`=1 at accept, B-reg ← ~`in_b` and carry-reg ← 1, with `in_cin` ignored.
  - Result is A−B; `out_cout`=1 means no borrow.
- Undefined:
  - The `in_sub` port is absent.
  - B-reg ← `in_b` and carry-reg ← `in_cin` always.

## Test plan
- A=3, B=5, cin=0 (default parameters) → `out_sum`=8, `out_cout`=0, `out_valid` rises 32 cycles after accept.
- A=0xFFFFFFFF, B=1, cin=0 → `out_sum`=0, `out_cout`=1. Also A=0x80000000, B=0x80000000, cin=1 → `out_sum`=1, `out_cout`=1.
- `out_ready` low for 10 cycles after DONE → `out_valid`=1 with `out_sum` stable throughout. `in_valid` pulsed during RUN/DONE is not accepted (`in_ready`=0).
- `p_reset` asserted mid-RUN at bit 10 → outputs at reset values immediately. A new request (7+9) after release → `out_sum`=16.
- ADDER_LAT=3 → each `add_ai/add_bi/add_ci` value held 3 cycles, `out_valid` 96 cycles after accept, and the sum is correct.
- With `ADDER_CTRL_SUB_EN`: A=5, B=3, `in_sub`=1 → `out_sum`=2, `out_cout`=1. A=3, B=5 → `out_sum`=0xFFFFFFFE, `out_cout`=0.
